// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle instruction sequencer (fetch/decode/exec/mem/wb)
// driving memory handshake, datapath load strobes and a retired-instruction counter.
module multicycle_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             pc_we,
    output logic             ir_we,
    output logic             alu_en,
    output logic             reg_we,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t           r_state;
    logic             r_st;
    logic             r_mem;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    logic w_halt, w_nop, w_alu, w_st, w_ld;

    assign w_halt = opcode == 5'b00000;
    assign w_nop  = opcode == 5'b00001;
    assign w_alu  = opcode[4:3] == 2'b01 || opcode == 5'b11001;
    assign w_st   = opcode == 5'b10000;
    assign w_ld   = opcode == 5'b10001;

    // Instruction class is latched in DECODE so later states never look at opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_st      <= 1'b0;
            r_mem     <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                FETCH:  r_state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    r_st  <= w_st;
                    r_mem <= w_st || w_ld;
                    if (w_halt) r_state <= HALT;
                    else if (w_nop) begin
                        r_state   <= FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end else if (w_alu || w_st || w_ld) r_state <= EXEC;
                    else begin
                        r_state   <= HALT;
                        r_illegal <= 1'b1;
                    end
                end
                EXEC:   r_state <= r_mem ? MEM : WB;
                MEM:    if (mem_ready) begin
                    r_state <= r_st ? FETCH : WB;
                    if (r_st) r_retired <= r_retired + CNT_W'(1);
                end
                WB:     begin
                    r_state   <= FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
                HALT:   r_state <= HALT;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so an abandoned handshake can never load IR or retire.
    always_comb begin
        mem_req = !rst && (r_state == FETCH || r_state == MEM);
        mem_we  = !rst && r_state == MEM && r_st;
        ir_we   = !rst && r_state == FETCH && mem_ready;
        pc_we   = ir_we;
        alu_en  = !rst && r_state == EXEC;
        reg_we  = !rst && r_state == WB;
    end

    assign state   = r_state;
    assign halted  = r_state == HALT;
    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule
